// File: rtl/analog_mux_sequencer_if.sv
// analog_mux_sequencer_if: request/enable in, switch enables and status out
interface analog_mux_sequencer_if #(
    parameter int N_SRC = 4
);
    localparam int GW = $clog2(N_SRC);
    logic             ena;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] sw_en;
    logic [GW-1:0]    grant_id;
    logic             pin_valid;
    logic             busy;
    modport master (output ena, req, input sw_en, grant_id, pin_valid, busy);
    modport slave  (input ena, req, output sw_en, grant_id, pin_valid, busy);
endinterface

// File: rtl/analog_mux_sequencer.sv
// analog_mux_sequencer: break-before-make round-robin scheduler for one shared analog pad
module analog_mux_sequencer #(
    parameter int N_SRC      = 4,
    parameter int BREAK_CYC  = 2,
    parameter int SETTLE_CYC = 8,
    parameter int HOLD_CYC   = 64
) (
    input logic clk,
    input logic rst_n,
    analog_mux_sequencer_if.slave bus
);
    localparam int GW   = $clog2(N_SRC);
    localparam int CMAX = (HOLD_CYC > SETTLE_CYC) ? ((HOLD_CYC > BREAK_CYC) ? HOLD_CYC : BREAK_CYC)
                                                  : ((SETTLE_CYC > BREAK_CYC) ? SETTLE_CYC : BREAK_CYC);
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] BREAK_M1  = CW'(BREAK_CYC - 1);
    localparam logic [CW-1:0] HOLD_M1   = CW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CONN, ST_BREAK} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]    grant_id_q, grant_id_d;
    logic [N_SRC-1:0] sw_en_q, sw_en_d;
    logic             pin_valid_q, pin_valid_d;
    logic             busy_q, busy_d;
    logic [GW-1:0]    win;
    logic             go, rel, others;

    // Walk downward so the nearest requester after rr_ptr overwrites the rest
    always_comb begin
        win = rr_ptr_q;
        for (int i = N_SRC; i >= 1; i--)
            if (bus.req[(int'(rr_ptr_q) + i) % N_SRC]) win = GW'((int'(rr_ptr_q) + i) % N_SRC);
    end

    assign go     = bus.ena && (|bus.req);
    assign rel    = !bus.req[grant_id_q] || !bus.ena;
    assign others = |(bus.req & ~(N_SRC'(1) << grant_id_q));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        sw_en_d     = sw_en_q;
        pin_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: if (go) begin
                state_d    = ST_SETTLE;
                cnt_d      = '0;
                rr_ptr_d   = win;
                grant_id_d = win;
                sw_en_d    = N_SRC'(1) << win;
            end
            ST_SETTLE: begin
                state_d     = rel ? ST_BREAK : (cnt_q == SETTLE_M1) ? ST_CONN : ST_SETTLE;
                cnt_d       = (rel || cnt_q == SETTLE_M1) ? '0 : cnt_q + 1'b1;
                sw_en_d     = rel ? '0 : sw_en_q;
                pin_valid_d = !rel && cnt_q == SETTLE_M1;
            end
            ST_CONN: if (rel || (cnt_q == HOLD_M1 && others)) begin
                state_d = ST_BREAK;
                cnt_d   = '0;
                sw_en_d = '0;
            end else begin
                cnt_d       = (cnt_q == HOLD_M1) ? cnt_q : cnt_q + 1'b1;
                pin_valid_d = 1'b1;
            end
            default: if (cnt_q != BREAK_M1) begin
                cnt_d = cnt_q + 1'b1;
            end else if (go) begin
                state_d    = ST_SETTLE;
                cnt_d      = '0;
                rr_ptr_d   = win;
                grant_id_d = win;
                sw_en_d    = N_SRC'(1) << win;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = state_d != ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rr_ptr_q    <= GW'(N_SRC - 1);
            grant_id_q  <= '0;
            sw_en_q     <= '0;
            pin_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            sw_en_q     <= sw_en_d;
            pin_valid_q <= pin_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.sw_en     = sw_en_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.pin_valid = pin_valid_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_analog_mux_sequencer.sv
// tb_analog_mux_sequencer: directed vectors with hand-computed expectations
module tb_analog_mux_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    analog_mux_sequencer_if #(.N_SRC(4)) bus ();

    analog_mux_sequencer #(
        .N_SRC(4), .BREAK_CYC(2), .SETTLE_CYC(8), .HOLD_CYC(64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int slots, hi, lo, multi, bad_sw, bad_pv, pv_seen, sw_seen;
        logic [3:0] prev, sw;
        bus.ena = 1'b0;
        bus.req = 4'b0000;
        step(3);
        check("rst_sw", 32'(bus.sw_en), 0);
        check("rst_gid", 32'(bus.grant_id), 0);
        check("rst_pv", 32'(bus.pin_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        bus.ena = 1'b1;
        step(1);
        bus.req = 4'b0001;
        step(1);
        check("grant_sw", 32'(bus.sw_en), 32'h1);
        check("grant_gid", 32'(bus.grant_id), 0);
        check("grant_busy", 32'(bus.busy), 1);
        check("grant_pv0", 32'(bus.pin_valid), 0);
        step(7);
        check("pv_c8", 32'(bus.pin_valid), 0);
        step(1);
        check("pv_c9", 32'(bus.pin_valid), 1);
        check("sw_c9", 32'(bus.sw_en), 32'h1);
        bus.req = 4'b0000;
        step(1);
        check("rel_sw1", 32'(bus.sw_en), 0);
        check("rel_pv1", 32'(bus.pin_valid), 0);
        check("rel_busy1", 32'(bus.busy), 1);
        step(1);
        check("rel_sw2", 32'(bus.sw_en), 0);
        check("rel_busy2", 32'(bus.busy), 1);
        step(1);
        check("rel_idle", 32'(bus.busy), 0);

        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        bus.req = 4'b1111;
        slots = 0; hi = 0; lo = 0; multi = 0; prev = 4'b0;
        for (int c = 0; c < 400 && slots < 5; c++) begin
            step(1);
            sw = bus.sw_en;
            if ($countones(sw) > 1) multi++;
            if (sw != 0) begin
                if (prev == 0) begin
                    if (slots > 0) check("rr_gap", 32'(lo), 2);
                    check("rr_gid", 32'(bus.grant_id), 32'(slots % 4));
                    check("rr_sw", 32'(sw), 32'(1 << (slots % 4)));
                    slots++;
                    hi = 0;
                end
                hi++;
            end else begin
                if (prev != 0) begin
                    check("rr_len", 32'(hi), 72);
                    lo = 0;
                end
                lo++;
            end
            prev = sw;
        end
        check("rr_slots", 32'(slots), 5);
        check("rr_onehot", 32'(multi), 0);
        bus.req = 4'b0000;
        step(4);
        check("rr_idle", 32'(bus.busy), 0);

        bus.req = 4'b0100;
        bad_sw = 0; bad_pv = 0;
        for (int c = 1; c <= 200; c++) begin
            step(1);
            if (bus.sw_en !== 4'b0100) bad_sw++;
            if (bus.pin_valid !== (c >= 9)) bad_pv++;
        end
        check("lone_sw", 32'(bad_sw), 0);
        check("lone_pv", 32'(bad_pv), 0);
        check("lone_gid", 32'(bus.grant_id), 2);
        bus.req = 4'b0000;
        step(3);
        check("lone_idle", 32'(bus.busy), 0);

        bus.req = 4'b0001;
        step(1);
        pv_seen = int'(bus.pin_valid);
        check("sd_sw", 32'(bus.sw_en), 32'h1);
        step(2);
        pv_seen += int'(bus.pin_valid);
        bus.req = 4'b0000;
        step(1);
        pv_seen += int'(bus.pin_valid);
        check("sd_brk1", 32'(bus.sw_en), 0);
        check("sd_busy1", 32'(bus.busy), 1);
        step(1);
        pv_seen += int'(bus.pin_valid);
        check("sd_busy2", 32'(bus.busy), 1);
        step(1);
        pv_seen += int'(bus.pin_valid);
        check("sd_idle", 32'(bus.busy), 0);
        check("sd_pv", 32'(pv_seen), 0);

        bus.req = 4'b0010;
        step(10);
        check("en_pv", 32'(bus.pin_valid), 1);
        check("en_gid", 32'(bus.grant_id), 1);
        bus.ena = 1'b0;
        step(1);
        check("en_sw", 32'(bus.sw_en), 0);
        sw_seen = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (bus.sw_en != 0) sw_seen++;
        end
        check("en_nogrant", 32'(sw_seen), 0);
        check("en_idle", 32'(bus.busy), 0);
        bus.ena = 1'b1;
        step(1);
        check("en_regrant", 32'(bus.sw_en), 32'h2);

        step(2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sw", 32'(bus.sw_en), 0);
        check("arst_pv", 32'(bus.pin_valid), 0);
        check("arst_busy", 32'(bus.busy), 0);
        step(1);
        rst_n = 1'b1;
        bus.req = 4'b1000;
        step(1);
        check("post_sw", 32'(bus.sw_en), 32'h8);
        check("post_gid", 32'(bus.grant_id), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
